// File: rtl/chip_pkg.sv
// Shared definitions for the edge-detection chip and its pixel load feeder.
// Holds the frame geometry, derived widths, the feeder FSM state type and
// a small helper for per-lane write enables.
package chip_pkg;

  localparam int unsigned IMG_DIM    = 20;
  localparam int unsigned BIT_LENGTH = 5;
  localparam int unsigned LANES      = 5;
  localparam int unsigned BEATS      = IMG_DIM * IMG_DIM / LANES;

  localparam int unsigned BEAT_W = $clog2(BEATS);
  localparam int unsigned LANE_W = $clog2(LANES);
  localparam int unsigned WORD_W = LANES * BIT_LENGTH;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } feed_state_t;

  function automatic logic [LANES-1:0] lane_onehot(input logic [LANE_W-1:0] lane);
    lane_onehot       = '0;
    lane_onehot[lane] = 1'b1;
  endfunction

endpackage

// File: rtl/pixel_frame_buf.sv
// One frame of packed pixel storage: BEATS words of LANES pixels each.
// Ports:
//   clk      in  write clock
//   wr_en    in  per-lane write enable (LANES bits)
//   wr_addr  in  beat index to write
//   wr_data  in  packed word; only enabled lanes are written
//   rd_addr  in  beat index to read
//   rd_data  out packed word at rd_addr (combinational read)
// Contents are not reset.
module pixel_frame_buf
  import chip_pkg::*;
(
  input  logic              clk,
  input  logic [LANES-1:0]  wr_en,
  input  logic [BEAT_W-1:0] wr_addr,
  input  word_t             wr_data,
  input  logic [BEAT_W-1:0] rd_addr,
  output word_t             rd_data
);

  word_t mem [BEATS];

  always_ff @(posedge clk) begin
    for (int unsigned j = 0; j < LANES; j++) begin
      if (wr_en[j]) begin
        mem[wr_addr][j*BIT_LENGTH +: BIT_LENGTH] <= wr_data[j*BIT_LENGTH +: BIT_LENGTH];
      end
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pixel_frame_feeder.sv
// Transmit side of the 5-lane pixel load interface.
// Accepts raster-order pixels over valid/ready, packs them 5 per word into a
// frame buffer, and once a full frame is held and the chip signals dst_ready,
// streams it as BEATS gap-free beats with load_end on the final beat.
// Ports:
//   clk, reset (async, active-low)
//   pix_valid/pix_data/pix_ready  host pixel handshake
//   dst_ready                     chip ready to load (sampled in WAIT)
//   pixel_out0..4                 beat lanes, lane 0 = lowest pixel index
//   load_end                      high on the last beat only
//   busy                          high while beats are driven
//   frame_done                    one-cycle pulse after the last beat
// Configuration: define PINGPONG_EN for two frame banks (fill overlaps burst,
// bursts leave in fill order). Undefined: single bank, strictly serial.
module pixel_frame_feeder
  import chip_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pix_valid,
  input  logic [BIT_LENGTH-1:0] pix_data,
  output logic                  pix_ready,
  input  logic                  dst_ready,
  output logic [BIT_LENGTH-1:0] pixel_out0,
  output logic [BIT_LENGTH-1:0] pixel_out1,
  output logic [BIT_LENGTH-1:0] pixel_out2,
  output logic [BIT_LENGTH-1:0] pixel_out3,
  output logic [BIT_LENGTH-1:0] pixel_out4,
  output logic                  load_end,
  output logic                  busy,
  output logic                  frame_done
);

`ifdef PINGPONG_EN
  localparam logic BANK_TOGGLE = 1'b1;
`else
  localparam logic BANK_TOGGLE = 1'b0;
`endif

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [BEAT_W-1:0] PREV_BEAT = BEAT_W'(BEATS - 2);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  feed_state_t       state;
  logic [LANE_W-1:0] wr_lane;
  logic [BEAT_W-1:0] wr_beat;
  logic [BEAT_W-1:0] rd_beat;
  logic              wr_bank;
  logic              rd_bank;
  logic [1:0]        full;
  word_t             out_word;

  logic              accept;
  logic              fill_last;
  logic              burst_last;
  logic [1:0]        full_nxt;
  logic              wr_bank_nxt;
  logic              rd_bank_nxt;
  logic [LANES-1:0]  lane_we;
  logic [BEAT_W-1:0] rd_addr;
  word_t             wr_word;
  word_t             rd_word;

  // Bank bookkeeping: a bank is "full" from its fill completion until the
  // end of its burst. Fill completion and burst end in the same cycle both
  // land in full_nxt, so neither event is lost.
  always_comb begin
    accept      = pix_valid & pix_ready;
    fill_last   = accept && (wr_lane == LAST_LANE) && (wr_beat == LAST_BEAT);
    burst_last  = (state == ST_BURST) && (rd_beat == LAST_BEAT);
    full_nxt    = full;
    if (fill_last)  full_nxt[wr_bank] = 1'b1;
    if (burst_last) full_nxt[rd_bank] = 1'b0;
    wr_bank_nxt = fill_last  ? (wr_bank ^ BANK_TOGGLE) : wr_bank;
    rd_bank_nxt = burst_last ? (rd_bank ^ BANK_TOGGLE) : rd_bank;
    lane_we     = accept ? lane_onehot(wr_lane) : '0;
    wr_word     = {LANES{pix_data}};
    // Prefetch the next beat so the output register reloads every cycle.
    if ((state == ST_BURST) && (rd_beat != LAST_BEAT)) begin
      rd_addr = rd_beat + 1'b1;
    end else begin
      rd_addr = '0;
    end
  end

`ifdef PINGPONG_EN
  word_t rd_word0;
  word_t rd_word1;

  pixel_frame_buf u_buf0 (
    .clk     (clk),
    .wr_en   (lane_we & {LANES{~wr_bank}}),
    .wr_addr (wr_beat),
    .wr_data (wr_word),
    .rd_addr (rd_addr),
    .rd_data (rd_word0)
  );

  pixel_frame_buf u_buf1 (
    .clk     (clk),
    .wr_en   (lane_we & {LANES{wr_bank}}),
    .wr_addr (wr_beat),
    .wr_data (wr_word),
    .rd_addr (rd_addr),
    .rd_data (rd_word1)
  );

  assign rd_word = rd_bank ? rd_word1 : rd_word0;
`else
  pixel_frame_buf u_buf0 (
    .clk     (clk),
    .wr_en   (lane_we),
    .wr_addr (wr_beat),
    .wr_data (wr_word),
    .rd_addr (rd_addr),
    .rd_data (rd_word)
  );
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_FILL;
      wr_lane    <= '0;
      wr_beat    <= '0;
      rd_beat    <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      full       <= '0;
      out_word   <= '0;
      load_end   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      pix_ready  <= 1'b0;
    end else begin
      full       <= full_nxt;
      wr_bank    <= wr_bank_nxt;
      rd_bank    <= rd_bank_nxt;
      pix_ready  <= ~full_nxt[wr_bank_nxt];
      frame_done <= 1'b0;

      if (accept) begin
        if (wr_lane == LAST_LANE) begin
          wr_lane <= '0;
          wr_beat <= (wr_beat == LAST_BEAT) ? '0 : wr_beat + 1'b1;
        end else begin
          wr_lane <= wr_lane + 1'b1;
        end
      end

      // The read side tracks the oldest full bank (rd_bank).
      case (state)
        ST_FILL: begin
          if (full_nxt[rd_bank]) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (dst_ready) begin
            state    <= ST_BURST;
            rd_beat  <= '0;
            out_word <= rd_word;
            load_end <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_BURST: begin
          if (rd_beat == LAST_BEAT) begin
            state      <= full_nxt[rd_bank_nxt] ? ST_WAIT : ST_FILL;
            rd_beat    <= '0;
            out_word   <= '0;
            load_end   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            rd_beat  <= rd_beat + 1'b1;
            out_word <= rd_word;
            load_end <= (rd_beat == PREV_BEAT);
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  assign pixel_out0 = out_word[0*BIT_LENGTH +: BIT_LENGTH];
  assign pixel_out1 = out_word[1*BIT_LENGTH +: BIT_LENGTH];
  assign pixel_out2 = out_word[2*BIT_LENGTH +: BIT_LENGTH];
  assign pixel_out3 = out_word[3*BIT_LENGTH +: BIT_LENGTH];
  assign pixel_out4 = out_word[4*BIT_LENGTH +: BIT_LENGTH];

endmodule
